ol_link_ctrl: RTL and testbench
===============================

# ol_link_ctrl

Parametrised optical-link bring-up controller for one serial transceiver lane. It sequences the lane through three phases: comma alignment, a counting-pattern link test, and normal data forwarding. It reports the link-test verdict on `error`/`send_err`. Unlike the first-generation controller it supports:
- configurable word width and phase lengths;
- a configurable lock threshold;
- synchronous reset;
- automatic retraining when receive-enable is lost in data mode.

## Interface
Parameters:
- `DW`, 16: data word width; must be a multiple of 8.
- `ALIGN_WORD`, 16'h50BC: alignment word. It is replicated to fill `DW` bits, LSB-first.
- `ALIGN_CYC`, 1040000: cycles spent in ALIGN; must be ≥ 2.
- `K_CYC`, 1039000: cycles at the start of ALIGN with K-flags asserted and TX disabled; must be < `ALIGN_CYC`.
- `TEST_CYC`, 4096: cycles spent in TEST; must be ≥ 2.
- `LOCK_RUN`, 2047: consecutive +1 RX steps required to declare lock; must be ≥ 1.
- `LOSS_MAX`, 64: consecutive `ena_rx`-low cycles in DATA that trigger retrain. A value of 0 disables retraining.

Ports:
- `clk` input 1: single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `live` input 1: link-permit. When low, the block is forced back to ALIGN.
- `data_tx` input DW: payload word to transmit in DATA.
- `data_rx` input DW: received word.
- `ena_rx` input 1: received word valid / receiver synchronised.
- `data_out` output DW: word to the transceiver TX.
- `ena_tx` output 1: TX enable.
- `datak` output DW/8: per-byte K-character flags.
- `error` output 1: link-test verdict; 0 means good.
- `send_err` output 1: high while the verdict is valid, i.e. in DATA.
- `state` output 2: current phase. 0 = ALIGN, 1 = TEST, 2 = DATA.
- `link_down` output 1: single-cycle pulse on a retrain triggered by loss in DATA.

## Operation
- Reset values:
  - outputs: `state`=ALIGN, `data_out`=0, `ena_tx`=1, `datak`=0, `error`=1, `send_err`=0, `link_down`=0;
  - internal: phase counter `ctrl`=0, TX counter=0, run counter=0, lock=0, loss counter=0, RX history=0.
- Priority: `rst` > `live`=0 > normal sequencing.
- `live`=0 in any state: on the next edge `state`=ALIGN, `ctrl`=0, `error`=1, `send_err`=0. `link_down` is not pulsed.
- ALIGN:
  - `data_out`=ALIGN_WORD.
  - While `ctrl` < `K_CYC`: `datak`=all ones and `ena_tx`=0. Otherwise `datak`=0 and `ena_tx`=1.
  - `error`=1, `send_err`=0, and `ctrl` increments each cycle.
  - When `ctrl`==`ALIGN_CYC`-1 and `live`=1: go to TEST. Clear `ctrl`, the TX counter, the run counter and lock.
- TEST:
  - `data_out`=TX counter, starting at 0 and incrementing by 1 per cycle, wrapping mod 2^DW.
  - `datak`=0, `ena_tx`=1, `error`=1, `send_err`=0.
  - RX check each cycle:
    - If `ena_rx`=1 and the previous sample was valid and (`data_rx` − previous `data_rx`) mod 2^DW == 1, the run counter increments, saturating at `LOCK_RUN`.
    - Otherwise the run counter clears.
    - The previous sample and its valid bit (`ena_rx`) are registered every cycle.
  - Lock sets, and stays set for the rest of TEST, when the run counter reaches `LOCK_RUN`. The counter reaching `LOCK_RUN` on the final TEST cycle counts.
  - When `ctrl`==`TEST_CYC`-1: go to DATA with `error`=~lock and `send_err`=1.
- DATA:
  - `data_out`=`data_tx` (registered), `datak`=0, `ena_tx`=1, `send_err`=1.
  - `error` holds the verdict latched on entry.
  - Loss counter: increments on `ena_rx`=0 and clears on `ena_rx`=1.
  - If `LOSS_MAX`>0 and the counter would reach `LOSS_MAX`:
    - go to ALIGN with `ctrl`=0;
    - `error`=1, `send_err`=0;
    - `link_down`=1 for exactly that cycle.
  - State value 3 is unreachable; if entered, the next cycle behaves as ALIGN with `ctrl`=0.
- Arithmetic:
  - `ctrl` width = clog2(max(`ALIGN_CYC`, `TEST_CYC`)) + 1, so it never wraps within a phase.
  - The run counter and loss counter saturate rather than wrap.
  - The TX counter and the RX difference wrap mod 2^DW, so 0xFFFF→0x0000 is a valid step at DW=16.

## Timing
- All outputs are registered and reflect the state entered at the same edge.
- `data_tx` → `data_out` latency is 1 cycle in DATA.
- The `datak`/`ena_tx` switch occurs on the edge where `ctrl` goes from `K_CYC`-1 to `K_CYC`.
- ALIGN lasts exactly `ALIGN_CYC` cycles with `live` high, and TEST lasts exactly `TEST_CYC` cycles.
- The first TEST word is 0 and appears on the first TEST cycle.
- `error`/`send_err` change on the same edge as `state` goes 1→2.
- Retrain: the first ALIGN cycle follows the `LOSS_MAX`-th consecutive low `ena_rx` sample.
- `rst` asserted mid-phase returns the block to its reset values on the next edge.

## Test plan
Bench parameters: `ALIGN_CYC`=32, `K_CYC`=24, `TEST_CYC`=64, `LOCK_RUN`=16, `LOSS_MAX`=4, DW=16.

- Reset, then `live`=1:
  - `state`=0 for 32 cycles; `datak`=2'b11 and `ena_tx`=0 for 24 cycles; `data_out`=16'h50BC throughout.
  - Then `state`=1 with `data_out` 0,1,2,….
- Loopback `data_rx`=`data_out` with `ena_rx`=1: after 64 TEST cycles, `state`=2, `error`=0, `send_err`=1. `data_out` follows `data_tx` with 1-cycle delay.
- Loopback with one corrupted word every 10 cycles during TEST: lock never set → in DATA, `error`=1, `send_err`=1.
- RX starting at 16'hFFF8 and incrementing: the wrap 0xFFFF→0x0000 is counted and `error`=0.
- In DATA, drop `ena_rx` for 3 cycles: no change. Drop it for 4 cycles: `link_down` pulses once, `state`=0, `error`=1, `send_err`=0, and the ALIGN sequence restarts.
- Cases with `live` low or `rst` high:
  - `live`=0 for one cycle mid-TEST → `state`=0 on the next cycle with a full 32-cycle ALIGN, and no `link_down`.
  - `rst` high in DATA → all outputs at their reset values next cycle.

Source files
------------

// File: rtl/ol_link_ctrl.sv
// Optical-link bring-up controller for one transceiver lane:
// comma alignment, counting-pattern link test, then data forwarding.
//
// state  | meaning
// ALIGN  | send alignment words, K-flags/TX-off for the first K_CYC cycles
// TEST   | send counting pattern, look for LOCK_RUN consecutive +1 RX steps
// DATA   | forward data_tx, hold the verdict, retrain on sustained RX loss
module ol_link_ctrl #(
  parameter int          DW         = 16,
  parameter logic [15:0] ALIGN_WORD = 16'h50BC,
  parameter int          ALIGN_CYC  = 1040000,
  parameter int          K_CYC      = 1039000,
  parameter int          TEST_CYC   = 4096,
  parameter int          LOCK_RUN   = 2047,
  parameter int          LOSS_MAX   = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            live,
  input  logic [DW-1:0]   data_tx,
  input  logic [DW-1:0]   data_rx,
  input  logic            ena_rx,
  output logic [DW-1:0]   data_out,
  output logic            ena_tx,
  output logic [DW/8-1:0] datak,
  output logic            error,
  output logic            send_err,
  output logic [1:0]      state,
  output logic            link_down
);

  localparam int MAXC = (ALIGN_CYC > TEST_CYC) ? ALIGN_CYC : TEST_CYC;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int KW   = DW / 8;
  localparam int RW   = $clog2(LOCK_RUN + 1);
  localparam int LW   = (LOSS_MAX > 0) ? $clog2(LOSS_MAX + 1) : 1;

  function automatic logic [DW-1:0] align_fill();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < DW; i++) v[i] = ALIGN_WORD[i % 16];
    return v;
  endfunction

  localparam logic [DW-1:0] ALIGN_FILL = align_fill();

  typedef enum logic [1:0] {
    ST_ALIGN = 2'd0,
    ST_TEST  = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_ctrl, w_ctrl_nxt;
  logic [DW-1:0]   r_tx_cnt, w_tx_cnt_nxt;
  logic [RW-1:0]   r_run, w_run_nxt, w_run_inc;
  logic            r_lock, w_lock_nxt;
  logic [LW-1:0]   r_loss, w_loss_nxt, w_loss_inc;
  logic [DW-1:0]   r_rx_prev;
  logic            r_rx_prev_vld;
  logic            w_rx_step;

  logic [DW-1:0]   r_data_out, w_data_out_nxt;
  logic            r_ena_tx, w_ena_tx_nxt;
  logic [KW-1:0]   r_datak, w_datak_nxt;
  logic            r_error, w_error_nxt;
  logic            r_send_err, w_send_err_nxt;
  logic            r_link_down, w_link_down_nxt;

  // Step check is modular, so the counter wrap is a legal +1.
  assign w_rx_step  = ena_rx & r_rx_prev_vld & ((data_rx - r_rx_prev) == DW'(1));
  assign w_run_inc  = (r_run == RW'(LOCK_RUN)) ? r_run : r_run + RW'(1);
  assign w_loss_inc = (r_loss == LW'(LOSS_MAX)) ? r_loss : r_loss + LW'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_ctrl_nxt      = r_ctrl;
    w_tx_cnt_nxt    = r_tx_cnt;
    w_run_nxt       = r_run;
    w_lock_nxt      = r_lock;
    w_loss_nxt      = '0;
    w_data_out_nxt  = r_data_out;
    w_ena_tx_nxt    = r_ena_tx;
    w_datak_nxt     = r_datak;
    w_error_nxt     = r_error;
    w_send_err_nxt  = r_send_err;
    w_link_down_nxt = 1'b0;

    if (!live) begin
      w_state_nxt = ST_ALIGN;
      w_ctrl_nxt  = '0;
    end else begin
      case (r_state)
        ST_ALIGN: begin
          if (r_ctrl == CW'(ALIGN_CYC - 1)) begin
            w_state_nxt    = ST_TEST;
            w_ctrl_nxt     = '0;
            w_tx_cnt_nxt   = DW'(1);
            w_run_nxt      = '0;
            w_lock_nxt     = 1'b0;
            w_data_out_nxt = '0;
            w_datak_nxt    = '0;
            w_ena_tx_nxt   = 1'b1;
            w_error_nxt    = 1'b1;
            w_send_err_nxt = 1'b0;
          end else begin
            w_ctrl_nxt = r_ctrl + CW'(1);
          end
        end
        ST_TEST: begin
          w_run_nxt  = w_rx_step ? w_run_inc : '0;
          w_lock_nxt = r_lock | (w_run_nxt == RW'(LOCK_RUN));
          w_datak_nxt  = '0;
          w_ena_tx_nxt = 1'b1;
          if (r_ctrl == CW'(TEST_CYC - 1)) begin
            w_state_nxt    = ST_DATA;
            w_ctrl_nxt     = '0;
            w_data_out_nxt = data_tx;
            w_error_nxt    = ~w_lock_nxt;
            w_send_err_nxt = 1'b1;
          end else begin
            w_ctrl_nxt     = r_ctrl + CW'(1);
            w_data_out_nxt = r_tx_cnt;
            w_tx_cnt_nxt   = r_tx_cnt + DW'(1);
            w_error_nxt    = 1'b1;
            w_send_err_nxt = 1'b0;
          end
        end
        ST_DATA: begin
          w_loss_nxt = ena_rx ? '0 : w_loss_inc;
          if ((LOSS_MAX > 0) && (w_loss_nxt == LW'(LOSS_MAX))) begin
            w_state_nxt     = ST_ALIGN;
            w_ctrl_nxt      = '0;
            w_loss_nxt      = '0;
            w_link_down_nxt = 1'b1;
          end else begin
            w_data_out_nxt = data_tx;
            w_datak_nxt    = '0;
            w_ena_tx_nxt   = 1'b1;
            w_send_err_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_ALIGN;
          w_ctrl_nxt  = '0;
        end
      endcase
    end

    // Every way into or through ALIGN shares one output decode keyed on the new ctrl.
    if (w_state_nxt == ST_ALIGN) begin
      w_data_out_nxt = ALIGN_FILL;
      w_error_nxt    = 1'b1;
      w_send_err_nxt = 1'b0;
      if (w_ctrl_nxt < CW'(K_CYC)) begin
        w_datak_nxt  = '1;
        w_ena_tx_nxt = 1'b0;
      end else begin
        w_datak_nxt  = '0;
        w_ena_tx_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_ALIGN;
      r_ctrl        <= '0;
      r_tx_cnt      <= '0;
      r_run         <= '0;
      r_lock        <= 1'b0;
      r_loss        <= '0;
      r_rx_prev     <= '0;
      r_rx_prev_vld <= 1'b0;
      r_data_out    <= '0;
      r_ena_tx      <= 1'b1;
      r_datak       <= '0;
      r_error       <= 1'b1;
      r_send_err    <= 1'b0;
      r_link_down   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ctrl        <= w_ctrl_nxt;
      r_tx_cnt      <= w_tx_cnt_nxt;
      r_run         <= w_run_nxt;
      r_lock        <= w_lock_nxt;
      r_loss        <= w_loss_nxt;
      r_rx_prev     <= data_rx;
      r_rx_prev_vld <= ena_rx;
      r_data_out    <= w_data_out_nxt;
      r_ena_tx      <= w_ena_tx_nxt;
      r_datak       <= w_datak_nxt;
      r_error       <= w_error_nxt;
      r_send_err    <= w_send_err_nxt;
      r_link_down   <= w_link_down_nxt;
    end
  end

  assign state     = r_state;
  assign data_out  = r_data_out;
  assign ena_tx    = r_ena_tx;
  assign datak     = r_datak;
  assign error     = r_error;
  assign send_err  = r_send_err;
  assign link_down = r_link_down;

endmodule

// File: tb/tb_ol_link_ctrl.sv
// Directed bench for ol_link_ctrl with short phases: align/test sequencing,
// lock verdicts (clean, corrupted, wrapping), loss retrain, live and reset.
module tb_ol_link_ctrl;

  logic        clk = 1'b0;
  logic        rst, live, ena_rx;
  logic [15:0] data_tx, data_rx, data_out;
  logic        ena_tx, error, send_err, link_down;
  logic [1:0]  datak, state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ol_link_ctrl #(
    .DW(16), .ALIGN_WORD(16'h50BC), .ALIGN_CYC(32), .K_CYC(24),
    .TEST_CYC(64), .LOCK_RUN(16), .LOSS_MAX(4)
  ) dut (
    .clk(clk), .rst(rst), .live(live), .data_tx(data_tx), .data_rx(data_rx),
    .ena_rx(ena_rx), .data_out(data_out), .ena_tx(ena_tx), .datak(datak),
    .error(error), .send_err(send_err), .state(state), .link_down(link_down)
  );

  typedef struct {
    logic        ena_rx;
    logic [15:0] data_tx;
    logic [1:0]  s;
    logic [15:0] d;
    logic [1:0]  k;
    logic        et, er, se, ld;
  } vec_t;

  vec_t dv[9];

  function automatic logic [23:0] pk(input logic [1:0] s, input logic [15:0] d,
                                     input logic [1:0] k, input logic et,
                                     input logic er, input logic se, input logic ld);
    return {s, d, k, et, er, se, ld};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Checks the current cycle as ALIGN cycle 0 and the following 31.
  task automatic align_phase(input logic first_ld);
    for (int i = 0; i < 32; i++) begin
      chk("align", pk(state, data_out, datak, ena_tx, error, send_err, link_down),
          pk(2'd0, 16'h50BC, (i < 24) ? 2'b11 : 2'b00, (i >= 24), 1'b1, 1'b0,
             (i == 0) ? first_ld : 1'b0));
      live    = 1'b1;
      ena_rx  = 1'b1;
      data_rx = 16'h50BC;
      @(negedge clk);
    end
  endtask

  // mode 0: clean loopback, 1: every 10th word corrupted, 2: ramp from FFF8 then RX lost
  task automatic test_phase(input int mode, input int n);
    for (int i = 0; i < n; i++) begin
      chk("test", pk(state, data_out, datak, ena_tx, error, send_err, link_down),
          pk(2'd1, 16'(i), 2'b00, 1'b1, 1'b1, 1'b0, 1'b0));
      live    = 1'b1;
      data_tx = 16'hC000 + 16'(i);
      case (mode)
        0: begin ena_rx = 1'b1; data_rx = 16'(i); end
        1: begin
          ena_rx  = 1'b1;
          data_rx = (i % 10 == 9) ? (16'(i) ^ 16'h8000) : 16'(i);
        end
        default: begin
          if (i < 24) begin ena_rx = 1'b1; data_rx = 16'hFFF8 + 16'(i); end
          else begin ena_rx = 1'b0; data_rx = 16'h0000; end
        end
      endcase
      @(negedge clk);
    end
  endtask

  task automatic data_entry(input logic exp_err);
    chk("data_entry", pk(state, data_out, datak, ena_tx, error, send_err, link_down),
        pk(2'd2, 16'hC03F, 2'b00, 1'b1, exp_err, 1'b1, 1'b0));
  endtask

  initial begin
    dv[0] = '{1'b1, 16'h1111, 2'd2, 16'h1111, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
    dv[1] = '{1'b0, 16'h2222, 2'd2, 16'h2222, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
    dv[2] = '{1'b0, 16'h3333, 2'd2, 16'h3333, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
    dv[3] = '{1'b0, 16'h4444, 2'd2, 16'h4444, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
    dv[4] = '{1'b1, 16'h5555, 2'd2, 16'h5555, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
    dv[5] = '{1'b0, 16'h6666, 2'd2, 16'h6666, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
    dv[6] = '{1'b0, 16'h7777, 2'd2, 16'h7777, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
    dv[7] = '{1'b0, 16'h8888, 2'd2, 16'h8888, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
    dv[8] = '{1'b0, 16'h9999, 2'd0, 16'h50BC, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; live = 1'b0; ena_rx = 1'b0; data_rx = '0; data_tx = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_state",     32'(state),     32'd0);
    chk("rst_data_out",  32'(data_out),  32'd0);
    chk("rst_ena_tx",    32'(ena_tx),    32'd1);
    chk("rst_datak",     32'(datak),     32'd0);
    chk("rst_error",     32'(error),     32'd1);
    chk("rst_send_err",  32'(send_err),  32'd0);
    chk("rst_link_down", 32'(link_down), 32'd0);

    rst = 1'b0;
    @(negedge clk);
    align_phase(1'b0);
    test_phase(0, 64);
    data_entry(1'b0);

    for (int j = 0; j < 9; j++) begin
      ena_rx  = dv[j].ena_rx;
      data_tx = dv[j].data_tx;
      @(negedge clk);
      chk("data_vec", pk(state, data_out, datak, ena_tx, error, send_err, link_down),
          pk(dv[j].s, dv[j].d, dv[j].k, dv[j].et, dv[j].er, dv[j].se, dv[j].ld));
    end

    align_phase(1'b1);
    test_phase(1, 64);
    data_entry(1'b1);

    rst = 1'b1; ena_rx = 1'b1;
    @(negedge clk);
    chk("rst_in_data", pk(state, data_out, datak, ena_tx, error, send_err, link_down),
        pk(2'd0, 16'h0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0));

    rst = 1'b0; live = 1'b0;
    @(negedge clk);
    align_phase(1'b0);
    test_phase(2, 64);
    data_entry(1'b0);

    ena_rx = 1'b1; live = 1'b0;
    @(negedge clk);
    align_phase(1'b0);
    test_phase(0, 10);
    live = 1'b0;
    @(negedge clk);
    align_phase(1'b0);
    test_phase(0, 64);
    data_entry(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
